// File: rtl/mips_io_responder_if.sv
// Processor data-bus and output-port signals of the memory-mapped I/O responder.
// master: processor / consumer side, slave: the responder itself.
interface mips_io_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        PortOutValid;
    logic        PortOutReady;

    modport master (
        output Address, WriteData, MemWrite, MemRead, PortIn, PortOutReady,
        input  ReadData, Hit, PortOut, PortOutValid
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, PortIn, PortOutReady,
        output ReadData, Hit, PortOut, PortOutValid
    );
endinterface

// File: rtl/mips_io_responder.sv
// Memory-mapped I/O responder for a MIPS data bus: a 16-byte window holding a
// 4-deep output FIFO (OUT_DATA), a synchronized 8-bit input port (IN_DATA) and
// a STATUS register with sticky overflow and input-change flags.
module mips_io_responder #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input logic               clk,
    input logic               reset,
    mips_io_responder_if.slave bus
);
    localparam logic [1:0] SEL_OUT    = 2'd0;
    localparam logic [1:0] SEL_IN     = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;

    // FIFO storage; never reset, only entries between the pointers are meaningful
    logic [31:0] fifo_mem [0:3];

    logic [1:0] rd_ptr_reg, rd_ptr_next;
    logic [1:0] wr_ptr_reg, wr_ptr_next;
    logic [2:0] count_reg, count_next;
    logic       ovf_reg, ovf_next;
    logic       in_chg_reg, in_chg_next;
    logic [7:0] sync_meta_reg;
    logic [7:0] sync_in_reg;
    logic [7:0] prev_in_reg;

    logic       hit;
    logic [1:0] sel;
    logic       wr_access;
    logic       rd_access;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push;
    logic       unused_addr_bits;

    // Byte offset inside a word carries no meaning for these word registers
    assign unused_addr_bits = ^bus.Address[1:0];

    assign hit       = (bus.Address[31:4] == IO_BASE[31:4]);
    assign sel       = bus.Address[3:2];
    assign wr_access = bus.MemWrite && hit;
    assign rd_access = bus.MemRead && hit;
    assign empty     = (count_reg == 3'd0);
    assign full      = (count_reg == 3'd4);
    assign pop       = !empty && bus.PortOutReady;
    // A full FIFO still accepts a store when the head leaves in the same cycle
    assign push      = wr_access && (sel == SEL_OUT) && (!full || pop);

    assign bus.Hit          = hit;
    assign bus.PortOutValid = !empty;
    assign bus.PortOut      = empty ? 32'd0 : fifo_mem[rd_ptr_reg];

    // Next-state for pointers, occupancy and the sticky flags (set beats clear)
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        in_chg_next = in_chg_reg;

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 2'd1;
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 2'd1;
        end
        if (push && !pop) begin
            count_next = count_reg + 3'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 3'd1;
        end

        if (wr_access && (sel == SEL_STATUS) && bus.WriteData[3]) begin
            ovf_next = 1'b0;
        end
        if (wr_access && (sel == SEL_OUT) && full && !pop) begin
            ovf_next = 1'b1;
        end

        if (rd_access && (sel == SEL_IN)) begin
            in_chg_next = 1'b0;
        end
        if (sync_in_reg != prev_in_reg) begin
            in_chg_next = 1'b1;
        end
    end

    // Control state and input synchronizer; reset overrides any push/pop/clear
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg    <= 2'd0;
            wr_ptr_reg    <= 2'd0;
            count_reg     <= 3'd0;
            ovf_reg       <= 1'b0;
            in_chg_reg    <= 1'b0;
            sync_meta_reg <= 8'd0;
            sync_in_reg   <= 8'd0;
            prev_in_reg   <= 8'd0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            ovf_reg       <= ovf_next;
            in_chg_reg    <= in_chg_next;
            sync_meta_reg <= bus.PortIn;
            sync_in_reg   <= sync_meta_reg;
            prev_in_reg   <= sync_in_reg;
        end
    end

    // FIFO write port; a store during reset is discarded
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr_reg] <= bus.WriteData;
        end
    end

    // Load data mux, zero unless this is a load that hits the window
    always_comb begin
        bus.ReadData = 32'd0;
        if (rd_access) begin
            case (sel)
                SEL_OUT:    bus.ReadData = {29'd0, count_reg};
                SEL_IN:     bus.ReadData = {24'd0, sync_in_reg};
                SEL_STATUS: bus.ReadData = {25'd0, count_reg, ovf_reg, in_chg_reg, full, empty};
                default:    bus.ReadData = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_io_responder.sv
// Self-checking bench for mips_io_responder: table of directed bus cycles with
// hand-derived expectations, hand-written input-port and reset sequences, and
// random traffic, all checked against a queue-based behavioural model.
module tb_mips_io_responder;
    logic clk = 1'b0;
    logic reset;

    mips_io_responder_if bus ();

    mips_io_responder #(.IO_BASE(32'hFFFF_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        mw;
        logic        mr;
        logic [7:0]  pin;
        logic        rdy;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    int tests  = 0;
    int errors = 0;

    // Behavioural model: FIFO as a queue, flags as bits, PortIn sample history
    logic [31:0] mq[$];
    bit          m_ovf;
    bit          m_chg;
    logic [7:0]  m_hist [3];   // [0] newest sample, [1] visible value, [2] previous visible value

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_chg = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = 8'd0;
    endtask

    task automatic drive(input vec_t v);
        bus.Address      = v.addr;
        bus.WriteData    = v.wd;
        bus.MemWrite     = v.mw;
        bus.MemRead      = v.mr;
        bus.PortIn       = v.pin;
        bus.PortOutReady = v.rdy;
    endtask

    // One bus cycle: drive, compare combinational outputs with the model, clock, update model
    task automatic apply(input vec_t v, input bit use_exp);
        logic [2:0]  cnt;
        logic        hit_e;
        logic [1:0]  sel;
        logic [31:0] rd_e;
        logic [31:0] out_e;
        bit          pop;
        drive(v);
        #2;
        cnt   = 3'(mq.size());
        hit_e = (v.addr[31:4] == 28'hFFFF000);
        sel   = v.addr[3:2];
        rd_e  = 32'd0;
        if (v.mr && hit_e) begin
            if (sel == 2'd0)      rd_e = {29'd0, cnt};
            else if (sel == 2'd1) rd_e = {24'd0, m_hist[1]};
            else if (sel == 2'd2) rd_e = {25'd0, cnt, m_ovf, m_chg, cnt == 3'd4, cnt == 3'd0};
        end
        out_e = (cnt != 0) ? mq[0] : 32'd0;
        check("hit", {31'd0, bus.Hit}, {31'd0, hit_e});
        check("read_data", bus.ReadData, rd_e);
        check("valid", {31'd0, bus.PortOutValid}, {31'd0, cnt != 0});
        check("port_out", bus.PortOut, out_e);
        if (use_exp) begin
            check("vec_read_data", bus.ReadData, v.exp_rd);
            check("vec_port_out", bus.PortOut, v.exp_out);
        end
        // model update from pre-edge state
        pop = (cnt != 0) && v.rdy;
        if (pop) void'(mq.pop_front());
        if (v.mw && hit_e && sel == 2'd0) begin
            if (cnt < 4 || pop) mq.push_back(v.wd);
            else m_ovf = 1'b1;
        end else if (v.mw && hit_e && sel == 2'd2 && v.wd[3]) begin
            m_ovf = 1'b0;
        end
        if (m_hist[1] != m_hist[2]) m_chg = 1'b1;
        else if (v.mr && hit_e && sel == 2'd1) m_chg = 1'b0;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = v.pin;
        @(posedge clk);
        #1;
    endtask

    // Reset cycle with arbitrary bus activity, which must be lost
    task automatic do_reset(input vec_t v);
        drive(v);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.PortOutValid}, 32'd0);
        check("rst_port_out", bus.PortOut, 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    localparam logic [31:0] A_OUT = 32'hFFFF_0000;
    localparam logic [31:0] A_IN  = 32'hFFFF_0004;
    localparam logic [31:0] A_ST  = 32'hFFFF_0008;
    localparam logic [31:0] A_RSV = 32'hFFFF_000C;
    localparam logic [31:0] A_FAR = 32'h1001_0000;

    vec_t tbl [24];
    vec_t idle;

    initial begin
        idle = '{A_FAR, 32'd0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'd0};
        // addr, wd, mw, mr, pin, rdy, exp_rd, exp_out
        tbl[0]  = '{A_OUT, 32'hA5A5_0001, 1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 32'h0};
        tbl[1]  = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h10, 32'hA5A5_0001};
        tbl[2]  = '{A_OUT, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h01, 32'hA5A5_0001};
        tbl[3]  = '{A_FAR, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'h00, 32'hA5A5_0001};
        tbl[4]  = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h01, 32'h0};
        tbl[5]  = '{A_OUT, 32'd1,         1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 32'h0};
        tbl[6]  = '{A_OUT, 32'd2,         1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 32'h1};
        tbl[7]  = '{A_OUT, 32'd3,         1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 32'h1};
        tbl[8]  = '{A_OUT, 32'd4,         1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 32'h1};
        tbl[9]  = '{A_OUT, 32'd5,         1'b1, 1'b0, 8'h00, 1'b0, 32'h00, 32'h1};
        tbl[10] = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h4A, 32'h1};
        tbl[11] = '{A_OUT, 32'd6,         1'b1, 1'b1, 8'h00, 1'b1, 32'h04, 32'h1};
        tbl[12] = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h4A, 32'h2};
        tbl[13] = '{A_ST,  32'h8,         1'b1, 1'b1, 8'h00, 1'b0, 32'h4A, 32'h2};
        tbl[14] = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h42, 32'h2};
        tbl[15] = '{A_RSV, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h00, 1'b0, 32'h00, 32'h2};
        tbl[16] = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h42, 32'h2};
        tbl[17] = '{A_FAR, 32'd7,         1'b1, 1'b1, 8'h00, 1'b0, 32'h00, 32'h2};
        tbl[18] = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h42, 32'h2};
        tbl[19] = '{A_OUT, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'h04, 32'h2};
        tbl[20] = '{A_OUT, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'h03, 32'h3};
        tbl[21] = '{A_OUT, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'h02, 32'h4};
        tbl[22] = '{A_OUT, 32'h0,         1'b0, 1'b1, 8'h00, 1'b1, 32'h01, 32'h6};
        tbl[23] = '{A_ST,  32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 32'h01, 32'h0};

        // Power-up reset held for a few cycles
        drive(idle);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset(idle);

        // Directed FIFO / STATUS / decode table
        for (int i = 0; i < 24; i++) apply(tbl[i], 1'b1);

        // Input port: visible after 2 edges, flag after 3, read clears, set beats clear
        do_reset(idle);
        apply('{A_ST,  32'h0, 1'b0, 1'b1, 8'h3C, 1'b0, 32'h01, 32'h0}, 1'b1);
        apply('{A_IN,  32'h0, 1'b0, 1'b1, 8'h3C, 1'b0, 32'h00, 32'h0}, 1'b1);
        apply('{A_ST,  32'h0, 1'b0, 1'b1, 8'h3C, 1'b0, 32'h01, 32'h0}, 1'b1);
        apply('{A_ST,  32'h0, 1'b0, 1'b1, 8'h3C, 1'b0, 32'h05, 32'h0}, 1'b1);
        apply('{A_IN,  32'h0, 1'b0, 1'b1, 8'h3C, 1'b0, 32'h3C, 32'h0}, 1'b1);
        apply('{A_ST,  32'h0, 1'b0, 1'b1, 8'h5A, 1'b0, 32'h01, 32'h0}, 1'b1);
        apply('{A_FAR, 32'h0, 1'b0, 1'b0, 8'h5A, 1'b0, 32'h00, 32'h0}, 1'b1);
        apply('{A_IN,  32'h0, 1'b0, 1'b1, 8'h5A, 1'b0, 32'h5A, 32'h0}, 1'b1);
        apply('{A_ST,  32'h0, 1'b0, 1'b1, 8'h5A, 1'b0, 32'h05, 32'h0}, 1'b1);

        // Reset with count=3, a store in flight and a consumer handshake
        do_reset(idle);
        apply('{A_OUT, 32'd11, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0},  1'b1);
        apply('{A_OUT, 32'd22, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd11}, 1'b1);
        apply('{A_OUT, 32'd33, 1'b1, 1'b1, 8'h00, 1'b0, 32'h2, 32'd11}, 1'b1);
        do_reset('{A_OUT, 32'd44, 1'b1, 1'b1, 8'h77, 1'b1, 32'h0, 32'h0});
        apply('{A_ST,  32'h0,  1'b0, 1'b1, 8'h00, 1'b0, 32'h01, 32'h0}, 1'b1);
        apply('{A_OUT, 32'h0,  1'b0, 1'b1, 8'h00, 1'b1, 32'h00, 32'h0}, 1'b1);

        // Random traffic against the model
        begin
            vec_t        v;
            logic [31:0] r;
            logic [7:0]  pin_cur;
            pin_cur = 8'h00;
            for (int n = 0; n < 600; n++) begin
                r = $urandom;
                case (r[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3, 3'd4: v.addr = A_OUT | {28'd0, r[7:4]};
                    3'd5:    v.addr = $urandom;
                    default: v.addr = A_FAR;
                endcase
                v.wd  = $urandom;
                v.mw  = r[8] | r[9];
                v.mr  = r[10];
                if (r[13:11] == 3'd0) pin_cur = r[23:16];
                v.pin = pin_cur;
                v.rdy = (r[15:14] == 2'd0);
                v.exp_rd  = 32'd0;
                v.exp_out = 32'd0;
                if (r[31:26] == 6'd0) do_reset(v);
                else apply(v, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/mips_io_responder.md
MIPS_IO_RESPONDER -- requirements
Module: mips_io_responder

Interface
REQ-001 The block SHALL have parameter IO_BASE, default 32'hFFFF_0000, the base address of a 16-byte I/O window; IO_BASE[3:0] SHALL be zero.
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  processor data address.
- WriteData  input  32  processor store data.
- MemWrite  input  1  store strobe, one cycle per store.
- MemRead  input  1  load strobe.
- ReadData  output  32  load data, combinational.
- Hit  output  1  Address[31:4] == IO_BASE[31:4], combinational.
- PortIn  input  8  asynchronous external input.
- PortOut  output  32  FIFO head data.
- PortOutValid  output  1  FIFO not empty.
- PortOutReady  input  1  consumer accepts the head.

Function
REQ-003 The register select SHALL be Address[3:2]; Address[1:0] SHALL be ignored.
- 0 = OUT_DATA.
- 1 = IN_DATA.
- 2 = STATUS.
- 3 = reserved.
REQ-004 Any access with Hit=0 SHALL be ignored.
REQ-005 ReadData SHALL be 0 unless MemRead=1 and Hit=1.
REQ-006 The output FIFO SHALL be 4 entries x 32 bits, with a 2-bit read pointer, a 2-bit write pointer that wraps 3->0, and a 3-bit count (0..4).
REQ-007 Push SHALL occur when MemWrite=1, Hit=1, select=0 and (count<4 or a pop occurs in the same cycle); WriteData SHALL enter the FIFO at the edge.
REQ-008 Pop SHALL occur when PortOutValid=1 and PortOutReady=1; the read pointer SHALL advance at the edge.
REQ-009 With simultaneous push and pop, count SHALL remain unchanged, including at count=4 and count=0.
REQ-010 A push attempted at count=4 without a pop SHALL be dropped and SHALL set the sticky flag OVF.
REQ-011 PortOutValid SHALL equal (count!=0). PortOut SHALL equal the head entry when count!=0, and 0 otherwise.
REQ-012 Latency: after a push into an empty FIFO, PortOutValid SHALL be 1 in the cycle following the write edge.
REQ-013 Input path:
- PortIn SHALL pass through a 2-flop synchronizer to sync_in[7:0], plus a third register prev_in.
- IN_CHG SHALL be set at any edge where sync_in != prev_in.
REQ-014 A read of IN_DATA SHALL return {24'b0, sync_in}; MemRead=1 with Hit=1 and select=1 SHALL clear IN_CHG at the edge.
REQ-015 If IN_CHG set and clear occur in the same cycle, set SHALL win.
REQ-016 A read of STATUS SHALL return {25'b0, count[2:0], OVF, IN_CHG, full, empty}.
- Bits [6:4] = count, bit 3 = OVF, bit 2 = IN_CHG, bit 1 = full, bit 0 = empty.
- full = (count==4); empty = (count==0).
REQ-017 A write to STATUS with WriteData[3]=1 SHALL clear OVF; other written bits SHALL be ignored.
- If an OVF set and clear occur in the same cycle, set SHALL win.
REQ-018 A read of OUT_DATA SHALL return {29'b0, count}. A read of reserved SHALL return 0, and a write to reserved SHALL have no effect.
REQ-019 MemRead and MemWrite asserted together SHALL each take effect independently; ReadData SHALL reflect pre-edge state.
REQ-020 Reads SHALL have no side effects other than REQ-014.

Reset
REQ-021 At a rising clk edge with reset=1, the block SHALL clear the FIFO pointers and count, OVF, IN_CHG, both synchronizer stages and prev_in to 0.
- FIFO storage contents need not be cleared.
REQ-022 During and after reset: PortOutValid=0, PortOut=0, ReadData per REQ-005 with all register fields 0, Hit combinational.
REQ-023 Reset SHALL take priority over any simultaneous push, pop or clear.
- Data pushed in the reset cycle SHALL be lost.
- A consumer handshake in the reset cycle SHALL not be counted as a pop.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Store 0xA5A5_0001 to 0xFFFF0000 with PortOutReady=0 -> next cycle PortOutValid=1, PortOut=0xA5A5_0001; STATUS reads 0x10.
- Five stores (1..5) with PortOutReady=0 -> count=4; STATUS reads 0x4A (count=4, OVF=1, full=1); drain yields 1,2,3,4; 5 is never output.
- At count=4, store 6 while PortOutReady=1 -> pop of head and push of 6 in the same cycle; count stays 4; OVF unchanged.
- PortIn 0x00->0x3C -> IN_DATA reads 0x3C after 2 edges, IN_CHG=1 after 3 edges; IN_DATA read clears IN_CHG; a new change in the clearing cycle leaves IN_CHG=1.
- Store 0x8 to STATUS (0xFFFF0008) -> OVF cleared; store to 0xFFFF000C and a load from 0x10010000 -> no state change, ReadData=0, Hit=0 on the latter.
- Reset asserted with count=3 and a store in flight -> next cycle count=0, PortOutValid=0, STATUS reads 0x01.
